// File: rtl/sec_check_encoder.sv
// sec_check_encoder: SEC check-bit encoder with 2-entry FIFO, word counter and one-shot fault injection.
module sec_check_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [7:0]       out_check,
  output logic             out_en,
  input  logic             inj_req,
  input  logic [5:0]       inj_pos,
  output logic             inj_armed,
  output logic             inj_bad,
  output logic [CNT_W-1:0] word_cnt
);
  logic [39:0] mem [2];
  logic        rd, wr;
  logic [1:0]  cnt;
  logic [5:0]  ipos;
  logic        push, pop, req_ok;
  logic [7:0]  chk;
  logic [39:0] ent;
  assign chk = {^(in_data & 32'h8888F0F0), ^(in_data & 32'h44440F0F),
                ^(in_data & 32'h2222FF00), ^(in_data & 32'h111100FF),
                ^(in_data & 32'hF0F08888), ^(in_data & 32'h0F0F4444),
                ^(in_data & 32'hFF002222), ^(in_data & 32'h00FF1111)};
  assign in_ready  = cnt != 2'd2;
  assign out_valid = cnt != 2'd0;
  assign out_en    = out_valid;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign req_ok    = inj_req && inj_pos < 6'd40;
  // Fault uses the position armed before this edge; a same-cycle request only arms the next push.
  assign ent = {chk, in_data} ^ (inj_armed ? 40'd1 << ipos : 40'd0);
  assign {out_check, out_data} = mem[rd];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      cnt       <= '0;
      ipos      <= '0;
      inj_armed <= 1'b0;
      inj_bad   <= 1'b0;
      word_cnt  <= '0;
    end else begin
      if (push) begin
        mem[wr] <= ent;
        wr      <= ~wr;
      end
      if (pop) begin
        rd       <= ~rd;
        word_cnt <= word_cnt + 1'b1;
      end
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (req_ok) begin
        inj_armed <= 1'b1;
        ipos      <= inj_pos;
      end else if (push) inj_armed <= 1'b0;
      if (inj_req && !req_ok) inj_bad <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sec_check_encoder.sv
// tb_sec_check_encoder: table vectors, directed corner sequences and random traffic vs a queue model.
module tb_sec_check_encoder;
  localparam int CW = 4;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, out_en;
  logic [31:0] in_data = 0, out_data;
  logic [7:0] out_check;
  logic inj_req = 0, inj_armed, inj_bad;
  logic [5:0] inj_pos = 0;
  logic [CW-1:0] word_cnt;
  int n_cmp = 0, n_bad = 0;
  logic [39:0] q[$];
  logic m_armed, m_bad;
  int m_pos, m_cnt;

  sec_check_encoder #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_check(out_check),
    .out_en(out_en), .inj_req(inj_req), .inj_pos(inj_pos), .inj_armed(inj_armed),
    .inj_bad(inj_bad), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit in_grp(int c, int k);
    if (k < 16)
      case (c)
        0, 1, 2, 3: return k % 4 == c;
        4: return k < 8;
        5: return k >= 8;
        6: return k % 8 < 4;
        default: return k % 8 >= 4;
      endcase
    case (c)
      0: return k < 24;
      1: return k >= 24;
      2: return (k - 16) % 8 < 4;
      3: return (k - 16) % 8 >= 4;
      default: return k % 4 == c - 4;
    endcase
  endfunction

  function automatic logic [7:0] ref_chk(logic [31:0] d);
    logic [7:0] c = 0;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 32; k++)
        if (in_grp(i, k)) c[i] = c[i] ^ d[k];
    return c;
  endfunction

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_armed = 0; m_bad = 0; m_pos = 0; m_cnt = 0;
  endtask

  task automatic cmp_model();
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("out_en", 64'(out_en), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("head_data", 64'(out_data), 64'(q[0][31:0]));
      chk("head_check", 64'(out_check), 64'(q[0][39:32]));
    end
    chk("inj_armed", 64'(inj_armed), 64'(m_armed));
    chk("inj_bad", 64'(inj_bad), 64'(m_bad));
    chk("word_cnt", 64'(word_cnt), 64'(m_cnt % (1 << CW)));
  endtask

  task automatic cyc(logic v, logic [31:0] d, logic r, logic rq, logic [5:0] p);
    logic [39:0] w;
    bit pu, po;
    in_valid = v; in_data = d; out_ready = r; inj_req = rq; inj_pos = p;
    cmp_model();
    pu = v && q.size() < 2;
    po = q.size() > 0 && r;
    w = {ref_chk(d), d};
    if (m_armed) w[m_pos] = ~w[m_pos];
    @(posedge clk);
    if (po) begin void'(q.pop_front()); m_cnt++; end
    if (pu) q.push_back(w);
    if (rq && p < 40) begin m_armed = 1; m_pos = int'(p); end
    else if (pu) m_armed = 0;
    if (rq && p >= 40) m_bad = 1;
    @(negedge clk);
    in_valid = 0; inj_req = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; in_valid = 0; inj_req = 0; out_ready = 0;
    model_clear();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct { logic [31:0] d; logic [7:0] c; } vec_t;
  vec_t tv[5];

  initial begin
    tv[0] = '{32'h00000000, 8'h00};
    tv[1] = '{32'h00000001, 8'h51};
    tv[2] = '{32'h00010000, 8'h15};
    tv[3] = '{32'h80000000, 8'h8A};
    tv[4] = '{32'hFFFFFFFF, 8'h00};
    model_clear();
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_out_check", 64'(out_check), 0);
    do_reset();
    // Table: each word visible one cycle after its push
    foreach (tv[i]) begin
      cyc(1, tv[i].d, 1, 0, 0);
      chk("tbl_valid", 64'(out_valid), 1);
      chk("tbl_data", 64'(out_data), 64'(tv[i].d));
      chk("tbl_check", 64'(out_check), 64'(tv[i].c));
    end
    cyc(0, 0, 1, 0, 0);
    // Backpressure
    do_reset();
    cyc(1, 32'hA5A5_0001, 0, 0, 0);
    cyc(1, 32'hA5A5_0002, 0, 0, 0);
    chk("bp_in_ready", 64'(in_ready), 0);
    cyc(1, 32'hA5A5_0003, 0, 0, 0);
    chk("bp_held_data", 64'(out_data), 64'h0000_0000_A5A5_0001);
    cyc(1, 32'hA5A5_0003, 1, 0, 0);
    cyc(1, 32'hA5A5_0003, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("bp_word_cnt", 64'(word_cnt), 3);
    // Injection into data bit 5
    do_reset();
    cyc(0, 0, 1, 1, 6'd5);
    chk("inj_armed_set", 64'(inj_armed), 1);
    cyc(1, 0, 1, 0, 0);
    chk("inj_armed_clr", 64'(inj_armed), 0);
    chk("inj_data", 64'(out_data), 64'h20);
    chk("inj_check", 64'(out_check), 0);
    cyc(1, 0, 1, 0, 0);
    chk("post_inj_data", 64'(out_data), 0);
    // Injection into check bit 7, then bad position
    cyc(0, 0, 1, 1, 6'd39);
    cyc(1, 1, 1, 0, 0);
    chk("inj39_data", 64'(out_data), 1);
    chk("inj39_check", 64'(out_check), 64'hD1);
    cyc(0, 0, 1, 1, 6'd45);
    chk("bad_set", 64'(inj_bad), 1);
    chk("bad_not_armed", 64'(inj_armed), 0);
    cyc(1, 1, 1, 0, 0);
    chk("bad_noflip", 64'(out_check), 64'h51);
    // Counter wrap: 17 words -> 1
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1, $urandom, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("wrap_cnt", 64'(word_cnt), 1);
    // Async reset with full FIFO and armed injection
    do_reset();
    cyc(1, 32'h1111_2222, 0, 0, 0);
    cyc(1, 32'h3333_4444, 0, 0, 0);
    cyc(0, 0, 0, 1, 6'd3);
    cyc(0, 0, 0, 1, 6'd50);
    #2 rst_n = 0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 0);
    chk("ar_out_en", 64'(out_en), 0);
    chk("ar_in_ready", 64'(in_ready), 1);
    chk("ar_out_data", 64'(out_data), 0);
    chk("ar_out_check", 64'(out_check), 0);
    chk("ar_armed", 64'(inj_armed), 0);
    chk("ar_bad", 64'(inj_bad), 0);
    chk("ar_cnt", 64'(word_cnt), 0);
    model_clear();
    @(negedge clk);
    rst_n = 1;
    cyc(1, 32'h0000_0001, 1, 0, 0);
    chk("ar_new_data", 64'(out_data), 1);
    chk("ar_new_check", 64'(out_check), 64'h51);
    cyc(0, 0, 1, 0, 0);
    // Random traffic against the queue model
    do_reset();
    for (int i = 0; i < 600; i++)
      cyc($urandom % 4 != 0, $urandom, $urandom % 3 != 0, $urandom % 8 == 0,
          6'($urandom_range(0, 44)));
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cmp_model();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
